// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// default latencies and a small magnitude helper used by the divider.
package mdu_pkg;

  // Operation codes presented on OP; 6 and 7 are no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  // Default number of BUSY cycles per operation class.
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Absolute value of a 32-bit operand when treated as signed, else unchanged.
  // The most negative value maps to 0x80000000, which is correct as unsigned.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational divide datapath: signed/unsigned select, truncating quotient,
// remainder with the sign of the dividend, and a zero-divisor flag.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div_zero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_neg_a    = i_signed & i_dividend[31];
  assign w_neg_b    = i_signed & i_divisor[31];
  assign w_mag_a    = md_mag(i_dividend, i_signed);
  assign w_mag_b    = md_mag(i_divisor, i_signed);
  assign o_div_zero = (i_divisor == 32'd0);

  // A zero divisor is replaced by 1 so the divider never sees x/0; the result
  // is discarded by the caller in that case anyway.
  assign w_den = o_div_zero ? 32'd1 : w_mag_b;
  assign w_uq  = w_mag_a / w_den;
  assign w_ur  = w_mag_a % w_den;

  // Unsigned magnitudes give truncation toward zero; restore signs afterwards.
  // 0x80000000 / -1 yields magnitude 0x80000000, whose negation wraps to itself.
  assign o_quot = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign o_rem  = w_neg_a ? -w_ur : w_ur;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit. A cycle counter models the latency;
// HI/LO are written only on the edge where the counter goes 1 -> 0.
// Optional feature: define MULT_DIV_UNIT_DIV_EN to build in DIV/DIVU; without
// it, OP 2/3 behave as no-ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // NOTE: declaration initialisers give the 0 pre-reset simulation state of the
  // architectural registers; the synchronous RESET still clears them in hardware.
  logic [CNT_W-1:0] r_cnt = '0;
  logic [31:0]      r_hi  = '0;
  logic [31:0]      r_lo  = '0;

  // Captured operands are consumed only while the counter runs, so they are
  // left out of reset.
  logic [31:0]      r_a  = '0;
  logic [31:0]      r_b  = '0;
  md_op_e           r_op = MD_MULT;

  md_op_e           w_op;
  logic             w_accept;
  logic             w_is_mult;
  logic             w_is_div;
  logic             w_done;
  logic             w_mul_sgn;
  logic [63:0]      w_prod;

  assign w_op      = md_op_e'(OP);
  assign BUSY      = (r_cnt != '0);
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign w_accept  = START & ~BUSY;
  assign w_done    = (r_cnt == CNT_W'(1));
  assign w_is_mult = (w_op == MD_MULT) || (w_op == MD_MULTU);

`ifdef MULT_DIV_UNIT_DIV_EN
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);

  mdu_div_core u_div_core (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (r_op == MD_DIV),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );
`else
  assign w_is_div = 1'b0;
`endif

  // Single 64-bit multiplier: sign-extend operands for MULT, zero-extend for
  // MULTU; the low 64 bits of the product are correct in both cases.
  assign w_mul_sgn = (r_op == MD_MULT);
  assign w_prod    = {{32{w_mul_sgn & r_a[31]}}, r_a} * {{32{w_mul_sgn & r_b[31]}}, r_b};

  // Capture operands and opcode on an accepted multi-cycle operation.
  always_ff @(posedge CLK) begin
    if (w_accept && (w_is_mult || w_is_div)) begin
      r_a  <= A;
      r_b  <= B;
      r_op <= w_op;
    end
  end

  // Latency counter and architectural HI/LO; RESET overrides start and completion.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_done) begin
        case (r_op)
          MD_MULT, MD_MULTU: begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
`ifdef MULT_DIV_UNIT_DIV_EN
          MD_DIV, MD_DIVU: begin
            if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end
`endif
          default: ;
        endcase
      end
    end else if (START) begin
      case (w_op)
        MD_MULT, MD_MULTU: r_cnt <= CNT_W'(MULT_CYCLES);
`ifdef MULT_DIV_UNIT_DIV_EN
        MD_DIV, MD_DIVU:   r_cnt <= CNT_W'(DIV_CYCLES);
`endif
        MD_MTHI:           r_hi  <= A;
        MD_MTLO:           r_lo  <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, the number of BUSY cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, the number of BUSY cycles for DIV/DIVU.
REQ-003 The block SHALL have port CLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port START, input, 1 bit: the operation in OP is issued this cycle.
REQ-006 The block SHALL have port OP, input, 3 bits, with these codes:
- 0 MULT
- 1 MULTU
- 2 DIV
- 3 DIVU
- 4 MTHI
- 5 MTLO
- 6 and 7: no-op
REQ-007 The block SHALL have port A, input, 32 bits: operand rs, taken from register file read port 1.
REQ-008 The block SHALL have port B, input, 32 bits: operand rt, taken from register file read port 2.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL sample A, B and OP only on a rising edge where START=1 and BUSY=0; a START with BUSY=1 SHALL be ignored.
REQ-013 An accepted MULT/MULTU SHALL load a cycle counter with MULT_CYCLES; a DIV/DIVU SHALL load it with DIV_CYCLES.
REQ-014 BUSY SHALL equal (counter != 0), registered, so it rises in the cycle after the accepting edge.
REQ-015 The counter SHALL decrement by 1 on each edge while nonzero.
REQ-016 HI/LO SHALL be updated on the edge where the counter goes 1->0; BUSY is low and the result visible in the following cycle.
REQ-017 Intermediate results SHALL NOT be visible on HI/LO before that edge.
REQ-018 MULT SHALL compute the signed 64-bit product; MULTU the unsigned product; {HI,LO} = product.
REQ-019 DIV/DIVU SHALL compute LO = quotient, truncated toward zero, and HI = remainder, carrying the sign of the dividend (A).
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Division by zero SHALL run the full DIV_CYCLES with BUSY high and leave HI/LO unchanged.
REQ-022 MTHI/MTLO accepted with BUSY=0 SHALL write A into HI/LO on the accepting edge; BUSY SHALL stay low; the other register SHALL be unchanged.
REQ-023 MTHI/MTLO with BUSY=1 SHALL be ignored; the pipeline stalls them via BUSY.
REQ-024 OP 6/7 with START=1 SHALL have no effect.
REQ-025 A new START SHALL be accepted in the first cycle BUSY is low after completion; back-to-back operations are allowed.

Reset
REQ-026 RESET=1 at a rising edge SHALL clear HI, LO and the counter to 0, giving BUSY=0.
REQ-027 RESET SHALL take priority over START and over any completing operation.
REQ-028 An in-flight operation SHALL be discarded by RESET with no HI/LO write.
REQ-029 Initial (pre-reset) simulation values SHALL also be 0.

Configuration
REQ-030 Macro MULT_DIV_UNIT_DIV_EN SHALL compile the divider in.
REQ-031 When MULT_DIV_UNIT_DIV_EN is undefined, OP 2/3 SHALL be treated as no-ops: BUSY stays low and HI/LO are unchanged.
REQ-032 All other behaviour SHALL be identical whether or not MULT_DIV_UNIT_DIV_EN is defined.

Structure
REQ-033 Shared package mdu_pkg SHALL hold the OP encodings (MD_MULT..MD_MTLO) and the default latency constants.
REQ-034 The divide datapath SHALL be the sub-module mdu_div_core: signed/unsigned select, quotient/remainder, zero-divisor flag.
REQ-035 mdu_div_core SHALL be instantiated only under MULT_DIV_UNIT_DIV_EN.
REQ-036 The multiplier SHALL stay inline in mult_div_unit.

Verification
REQ-037 MULT: A=0xFFFFFFFE (-2), B=3, START -> BUSY high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-038 MULTU: A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-039 DIV: A=0xFFFFFFF9 (-7), B=2 -> BUSY for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7, B=0 -> BUSY for 10 cycles, HI/LO unchanged.
REQ-040 MTHI A=0x12345678 while idle -> HI=0x12345678 next cycle with BUSY low; a MULT then MTLO issued 2 cycles later (BUSY=1) -> MTLO ignored, LO = product.
REQ-041 RESET asserted at cycle 3 of a DIV -> next cycle BUSY=0, HI=LO=0; a START in the following cycle is accepted normally.
REQ-042 Build without MULT_DIV_UNIT_DIV_EN: DIV START -> BUSY stays low and HI/LO unchanged; MULT still behaves per REQ-037.
